usb_setup_capture: RTL and testbench

- Upstream stage of the endpoint-0 standard-request handler. Sits between the transaction layer and that handler.
- During a SETUP transaction on the control endpoint, it collects the 8-byte setup data stream and checks its length.
- Only on a successful transaction does it commit the decoded fields: bm_request_type, b_request, w_value, w_index, w_length.
- Pulses setup_new when it commits; pulses setup_err and discards the packet on a bad length or failed transaction.

---
 rtl/usb_setup_capture.sv | 144 ++++++++++++++
 tb/tb_usb_setup_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_setup_capture.sv
// Endpoint-0 SETUP packet capture: collects the 8-byte setup stream, checks its length and
// commits the decoded request fields only when the transaction completes successfully.
module usb_setup_capture #(
    parameter logic [3:0] CTRL_EP   = 4'd0,
    parameter logic [3:0] SETUP_LEN = 4'd8
) (
    input  logic        clk,
    input  logic        rst0_async,
    input  logic        rst0_sync,
    input  logic [1:0]  trsac_type,
    input  logic [3:0]  trsac_ep,
    input  logic [1:0]  trsac_req_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_wr,
    output logic [7:0]  bm_request_type,
    output logic [7:0]  b_request,
    output logic [15:0] w_value,
    output logic [15:0] w_index,
    output logic [15:0] w_length,
    output logic        setup_new,
    output logic        setup_err
);

    localparam logic [1:0] TYPE_SETUP = 2'd0;

    localparam logic [1:0] REQ_OK     = 2'd0;
    localparam logic [1:0] REQ_ACTIVE = 2'd1;
    localparam logic [1:0] REQ_FAIL   = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [3:0] SHADOW_LEN = 4'd8;

    logic [1:0] state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [7:0] shadow_q [8];
    logic       commit_q, commit_d;
    logic       fail_q, fail_d;
    logic       shadow_wr;
    logic       start;

    assign start = (trsac_req_in == REQ_ACTIVE) && (trsac_type == TYPE_SETUP)
                   && (trsac_ep == CTRL_EP);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        commit_d  = 1'b0;
        fail_d    = 1'b0;
        shadow_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CAPTURE;
                    count_d = 4'd0;
                end
            end
            ST_CAPTURE: begin
                if (rx_wr) begin
                    if (count_q < SETUP_LEN && count_q < SHADOW_LEN) begin
                        shadow_wr = 1'b1;
                        count_d   = count_q + 4'd1;
                    end else begin
                        // Overflow marker: any byte beyond the setup length poisons the packet
                        count_d = SETUP_LEN + 4'd1;
                    end
                end
                // Length check uses the count including a byte arriving with the status
                if (trsac_req_in == REQ_OK) begin
                    state_d = ST_DONE;
                    if (count_d == SETUP_LEN) begin
                        commit_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end else if (trsac_req_in == REQ_FAIL) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (trsac_req_in != REQ_ACTIVE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state_q         <= ST_IDLE;
            count_q         <= 4'd0;
            commit_q        <= 1'b0;
            fail_q          <= 1'b0;
            bm_request_type <= 8'h00;
            b_request       <= 8'h00;
            w_value         <= 16'h0000;
            w_index         <= 16'h0000;
            w_length        <= 16'h0000;
            setup_new       <= 1'b0;
            setup_err       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else if (!rst0_sync) begin
            state_q         <= ST_IDLE;
            count_q         <= 4'd0;
            commit_q        <= 1'b0;
            fail_q          <= 1'b0;
            bm_request_type <= 8'h00;
            b_request       <= 8'h00;
            w_value         <= 16'h0000;
            w_index         <= 16'h0000;
            w_length        <= 16'h0000;
            setup_new       <= 1'b0;
            setup_err       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            commit_q  <= commit_d;
            fail_q    <= fail_d;
            setup_new <= commit_q;
            setup_err <= fail_q;
            if (shadow_wr) begin
                shadow_q[count_q[2:0]] <= rx_data;
            end
            // Commit one cycle after the status so a byte arriving with REQ_OK is included
            if (commit_q) begin
                bm_request_type <= shadow_q[0];
                b_request       <= shadow_q[1];
                w_value         <= {shadow_q[3], shadow_q[2]};
                w_index         <= {shadow_q[5], shadow_q[4]};
                w_length        <= {shadow_q[7], shadow_q[6]};
            end
        end
    end

endmodule

// File: tb/tb_usb_setup_capture.sv
// Scoreboard bench for usb_setup_capture: stimulus pushes expected pulses, a monitor checks them.
module tb_usb_setup_capture;

    localparam logic [1:0] T_SETUP = 2'd0;
    localparam logic [1:0] T_OUT   = 2'd1;
    localparam logic [1:0] T_IN    = 2'd2;
    localparam logic [1:0] R_OK    = 2'd0;
    localparam logic [1:0] R_ACT   = 2'd1;
    localparam logic [1:0] R_FAIL  = 2'd2;

    logic        clk = 1'b0;
    logic        rst0_async = 1'b0;
    logic        rst0_sync = 1'b1;
    logic [1:0]  trsac_type = T_IN;
    logic [3:0]  trsac_ep = 4'd0;
    logic [1:0]  trsac_req_in = R_OK;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_wr = 1'b0;
    logic [7:0]  bm_request_type;
    logic [7:0]  b_request;
    logic [15:0] w_value;
    logic [15:0] w_index;
    logic [15:0] w_length;
    logic        setup_new;
    logic        setup_err;

    usb_setup_capture dut (
        .clk             (clk),
        .rst0_async      (rst0_async),
        .rst0_sync       (rst0_sync),
        .trsac_type      (trsac_type),
        .trsac_ep        (trsac_ep),
        .trsac_req_in    (trsac_req_in),
        .rx_data         (rx_data),
        .rx_wr           (rx_wr),
        .bm_request_type (bm_request_type),
        .b_request       (b_request),
        .w_value         (w_value),
        .w_index         (w_index),
        .w_length        (w_length),
        .setup_new       (setup_new),
        .setup_err       (setup_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_new;
        int          cyc;
        logic [63:0] fields;
    } exp_t;

    exp_t        sb [$];
    logic [7:0]  pl [$];
    logic [63:0] cur = 64'h0;
    int          checks = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: first eight payload bytes, little-endian, byte i in bits [8i+7:8i]
    function automatic logic [63:0] pack_payload();
        logic [63:0] f = 64'h0;
        for (int i = 0; i < 8 && i < pl.size(); i++) f[8*i +: 8] = pl[i];
        return f;
    endfunction

    always @(negedge clk) begin : monitor
        logic [63:0] act;
        exp_t        e;
        if (mon_en) begin
            act = {w_length, w_index, w_value, b_request, bm_request_type};
            chk("pulse_exclusive", {63'h0, setup_new & setup_err}, 64'h0);
            if (setup_new || setup_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {62'h0, setup_new, setup_err}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("setup_new_kind", {63'h0, setup_new}, {63'h0, e.is_new});
                    chk("setup_err_kind", {63'h0, setup_err}, {63'h0, !e.is_new});
                    chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.is_new) begin
                        chk("fields_commit", act, e.fields);
                        cur = e.fields;
                    end else begin
                        chk("fields_kept_on_err", act, cur);
                    end
                end
            end else begin
                chk("fields_stable", act, cur);
            end
        end
    end

    task automatic go_idle();
        rx_wr        = 1'b0;
        trsac_req_in = R_OK;
        trsac_type   = T_IN;
        trsac_ep     = 4'd0;
    endtask

    // One transaction: trigger cycle, payload bytes from pl, final status held for hold cycles
    task automatic send(input logic [1:0] typ, input logic [3:0] ep, input logic [1:0] status,
                        input bit last_with, input int hold, input bit gaps);
        int   n  = pl.size();
        int   nb = (last_with && n > 0) ? n - 1 : n;
        exp_t e;
        @(posedge clk); #1;
        trsac_req_in = R_ACT; trsac_type = typ; trsac_ep = ep; rx_wr = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; rx_wr = 1'b0; end
            @(posedge clk); #1;
            rx_wr = 1'b1; rx_data = pl[i];
        end
        @(posedge clk); #1;
        trsac_req_in = status;
        rx_wr = last_with && n > 0;
        if (last_with && n > 0) rx_data = pl[n-1];
        if (typ == T_SETUP && ep == 4'd0) begin
            e.is_new = (status == R_OK) && (n == 8);
            e.cyc    = cyc + 2;
            e.fields = pack_payload();
            sb.push_back(e);
        end
        for (int i = 1; i < hold; i++) begin @(posedge clk); #1; rx_wr = 1'b0; end
        @(posedge clk); #1;
        go_idle();
        repeat (2) @(posedge clk);
    endtask

    task automatic abort_by_reset(input bit use_async);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(posedge clk); #1;
        trsac_req_in = R_ACT; trsac_type = T_SETUP; trsac_ep = 4'd0;
        foreach (pl[i]) begin @(posedge clk); #1; rx_wr = 1'b1; rx_data = pl[i]; end
        @(posedge clk); #1;
        go_idle();
        if (use_async) begin
            rst0_async = 1'b0; cur = 64'h0;
            repeat (2) @(posedge clk);
            #1 rst0_async = 1'b1;
        end else begin
            rst0_sync = 1'b0;
            @(posedge clk); #1;
            cur = 64'h0;
            @(posedge clk); #1;
            rst0_sync = 1'b1;
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        chk("reset_fields", {w_length, w_index, w_value, b_request, bm_request_type}, 64'h0);
        chk("reset_pulses", {62'h0, setup_new, setup_err}, 64'h0);
        rst0_async = 1'b1;
        repeat (2) @(posedge clk);

        pl = '{8'h00, 8'h05, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send(T_SETUP, 4'd0, R_OK, 1'b0, 1, 1'b0);
        pl = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
        send(T_SETUP, 4'd0, R_FAIL, 1'b0, 1, 1'b0);
        pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        send(T_SETUP, 4'd0, R_OK, 1'b0, 1, 1'b0);
        pl = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};
        send(T_SETUP, 4'd0, R_OK, 1'b0, 1, 1'b0);
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        send(T_OUT, 4'd0, R_OK, 1'b0, 1, 1'b0);
        send(T_SETUP, 4'd3, R_OK, 1'b0, 1, 1'b0);

        abort_by_reset(1'b1);
        pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
        send(T_SETUP, 4'd0, R_OK, 1'b0, 1, 1'b0);
        abort_by_reset(1'b0);

        pl = '{8'h21, 8'h09, 8'h00, 8'h02, 8'h00, 8'h00, 8'h08, 8'h00};
        send(T_SETUP, 4'd0, R_OK, 1'b1, 3, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int          n;
            logic [1:0]  typ;
            logic [3:0]  ep;
            logic [1:0]  st;
            typ = ($urandom_range(0, 4) == 0) ? T_OUT : T_SETUP;
            ep  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            st  = ($urandom_range(0, 4) == 0) ? R_FAIL : R_OK;
            n   = $urandom_range(0, 1) ? 8 : $urandom_range(5, 10);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            send(typ, ep, st, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
